// File: rtl/multi_phase_light_ctrl.sv
// N-approach traffic light controller: round-robin service with min/max green,
// fixed yellow and all-red clearance; exactly one approach is ever non-red.
module multi_phase_light_ctrl #(
    parameter int unsigned N_DIR     = 2,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 16,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 1,
    localparam int unsigned AW       = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DIR-1:0] sense_i,
    output logic [N_DIR-1:0] red_o,
    output logic [N_DIR-1:0] yellow_o,
    output logic [N_DIR-1:0] green_o,
    output logic [AW-1:0]    active_o,
    output logic [1:0]       phase_o
);

    typedef enum logic [1:0] {
        StGreen  = 2'b00,
        StYellow = 2'b01,
        StAllred = 2'b10
    } phase_e;

    localparam logic [CNT_W-1:0] GMin1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMax1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Yel1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] Ar1   = CNT_W'(ALLRED_T - 1);

    phase_e           phase_q, phase_d;
    logic [AW-1:0]    active_q, active_d;
    logic [CNT_W-1:0] t_q, t_d;

    logic          other_req;
    logic          found;
    logic [AW-1:0] next_active;
    int            idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= StGreen;
            active_q <= '0;
            t_q      <= '0;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            t_q      <= t_d;
        end
    end

    always_comb begin
        other_req = 1'b0;
        for (int j = 0; j < int'(N_DIR); j++) begin
            if (AW'(j) != active_q && sense_i[j]) other_req = 1'b1;
        end
    end

    // Search starts one past the current owner and ends on the owner itself.
    always_comb begin
        next_active = AW'((int'(active_q) + 1) % int'(N_DIR));
        found       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= int'(N_DIR); k++) begin
            idx = (int'(active_q) + k) % int'(N_DIR);
            if (!found && sense_i[idx]) begin
                found       = 1'b1;
                next_active = AW'(idx);
            end
        end
    end

    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        t_d      = t_q;
        unique case (phase_q)
            StGreen: begin
                if (other_req && (t_q == GMax1 || (t_q >= GMin1 && !sense_i[active_q]))) begin
                    phase_d = StYellow;
                    t_d     = '0;
                end else if (t_q < GMax1) begin
                    t_d = t_q + 1'b1;
                end
            end
            StYellow: begin
                if (t_q == Yel1) begin
                    phase_d = StAllred;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            StAllred: begin
                if (t_q == Ar1) begin
                    phase_d  = StGreen;
                    active_d = next_active;
                    t_d      = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: begin
                phase_d = StGreen;
                t_d     = '0;
            end
        endcase
    end

    always_comb begin
        green_o  = '0;
        yellow_o = '0;
        if (phase_q == StGreen)  green_o[active_q]  = 1'b1;
        if (phase_q == StYellow) yellow_o[active_q] = 1'b1;
        red_o    = ~(green_o | yellow_o);
        active_o = active_q;
        phase_o  = phase_q;
    end

endmodule

// File: tb/tb_multi_phase_light_ctrl.sv
// Directed bench for multi_phase_light_ctrl: a 2-approach instance for timing
// scenarios and a 4-approach instance for round-robin selection.
module tb_multi_phase_light_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] sense;
    logic [1:0] red, yellow, green;
    logic [0:0] active;
    logic [1:0] phase;

    logic [3:0] sense4;
    logic [3:0] red4, yellow4, green4;
    logic [1:0] active4;
    logic [1:0] phase4;

    int errors = 0;
    int checks = 0;

    multi_phase_light_ctrl u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .sense_i  (sense),
        .red_o    (red),
        .yellow_o (yellow),
        .green_o  (green),
        .active_o (active),
        .phase_o  (phase)
    );

    multi_phase_light_ctrl #(.N_DIR(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .sense_i  (sense4),
        .red_o    (red4),
        .yellow_o (yellow4),
        .green_o  (green4),
        .active_o (active4),
        .phase_o  (phase4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves both DUTs in cycle 0 of GREEN, 1 time unit after an edge.
    task automatic do_reset(input logic [1:0] s, input logic [3:0] s4);
        sense  = s;
        sense4 = s4;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        sense  = 2'b01;
        sense4 = 4'b0001;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({green, yellow, red, active, phase} !== {2'b01, 2'b00, 2'b10, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_async: got g=%b y=%b r=%b a=%0d p=%b, want g=01 y=00 r=10 a=0 p=00",
                     green, yellow, red, active, phase);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            checks++;
            if ({green, yellow, red, active, phase} !== {2'b01, 2'b00, 2'b10, 1'b0, 2'b00}) begin
                errors++;
                $display("FAIL idle_hold c%0d: got g=%b y=%b r=%b a=%0d p=%b, want g=01 y=00 r=10 a=0 p=00",
                         i, green, yellow, red, active, phase);
            end
        end
    endtask

    task automatic test_min_switch();
        logic [1:0] eg, ey, er, ep;
        logic       ea;
        do_reset(2'b10, 4'b0000);
        for (int c = 0; c <= 8; c++) begin
            if (c <= 3) begin
                eg = 2'b01; ey = 2'b00; er = 2'b10; ea = 1'b0; ep = 2'b00;
            end else if (c <= 6) begin
                eg = 2'b00; ey = 2'b01; er = 2'b10; ea = 1'b0; ep = 2'b01;
            end else if (c == 7) begin
                eg = 2'b00; ey = 2'b00; er = 2'b11; ea = 1'b0; ep = 2'b10;
            end else begin
                eg = 2'b10; ey = 2'b00; er = 2'b01; ea = 1'b1; ep = 2'b00;
            end
            checks++;
            if ({green, yellow, red, active, phase} !== {eg, ey, er, ea, ep}) begin
                errors++;
                $display("FAIL min_switch c%0d: got g=%b y=%b r=%b a=%0d p=%b, want g=%b y=%b r=%b a=%0d p=%b",
                         c, green, yellow, red, active, phase, eg, ey, er, ea, ep);
            end
            step();
        end
    endtask

    task automatic test_max_green();
        int n;
        int m;
        do_reset(2'b11, 4'b0000);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (active !== 1'(g % 2)) begin
                errors++;
                $display("FAIL max_green_active g%0d: got %0d, want %0d", g, active, g % 2);
            end
            n = 0;
            while (phase == 2'b00 && n < 40) begin
                n++;
                step();
            end
            checks++;
            if (n != 16) begin
                errors++;
                $display("FAIL max_green_len g%0d: got %0d cycles, want 16", g, n);
            end
            m = 0;
            while (phase != 2'b00 && m < 10) begin
                m++;
                step();
            end
            checks++;
            if (m != 4) begin
                errors++;
                $display("FAIL max_green_clear g%0d: got %0d cycles, want 4", g, m);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] s_ar [3];
        logic [1:0] e_a  [3];
        s_ar[0] = 4'b1000; e_a[0] = 2'd3;
        s_ar[1] = 4'b0000; e_a[1] = 2'd1;
        s_ar[2] = 4'b0101; e_a[2] = 2'd2;
        for (int i = 0; i < 3; i++) begin
            do_reset(2'b00, 4'b1000);
            for (int c = 0; c < 7; c++) step();
            checks++;
            if (phase4 !== 2'b10 || red4 !== 4'b1111) begin
                errors++;
                $display("FAIL rr_allred case%0d: got p=%b r=%b, want p=10 r=1111", i, phase4, red4);
            end
            sense4 = s_ar[i];
            step();
            checks++;
            if (active4 !== e_a[i] || green4 !== (4'b0001 << e_a[i]) || phase4 !== 2'b00) begin
                errors++;
                $display("FAIL rr_next case%0d: got a=%0d g=%b p=%b, want a=%0d g=%b p=00",
                         i, active4, green4, phase4, e_a[i], 4'b0001 << e_a[i]);
            end
        end
    endtask

    task automatic test_late_demand();
        do_reset(2'b00, 4'b0000);
        step();
        sense = 2'b10;
        step();
        sense = 2'b00;
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (phase !== 2'b00 || green !== 2'b01) begin
                errors++;
                $display("FAIL late_pulse c%0d: got p=%b g=%b, want p=00 g=01", i + 2, phase, green);
            end
            step();
        end
        do_reset(2'b00, 4'b0000);
        step();
        sense = 2'b10;
        step();
        step();
        checks++;
        if (phase !== 2'b00 || green !== 2'b01) begin
            errors++;
            $display("FAIL late_hold_c3: got p=%b g=%b, want p=00 g=01", phase, green);
        end
        step();
        sense = 2'b00;
        checks++;
        if (phase !== 2'b01 || yellow !== 2'b01) begin
            errors++;
            $display("FAIL late_hold_c4: got p=%b y=%b, want p=01 y=01", phase, yellow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2'b10, 4'b0000);
        for (int c = 0; c < 8; c++) step();
        checks++;
        if (green !== 2'b10 || active !== 1'b1) begin
            errors++;
            $display("FAIL mid_green1: got g=%b a=%0d, want g=10 a=1", green, active);
        end
        sense = 2'b01;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (phase !== 2'b01 || yellow !== 2'b10) begin
            errors++;
            $display("FAIL mid_yellow1: got p=%b y=%b, want p=01 y=10", phase, yellow);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({green, yellow, red, active, phase} !== {2'b01, 2'b00, 2'b10, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL mid_async_rst: got g=%b y=%b r=%b a=%0d p=%b, want g=01 y=00 r=10 a=0 p=00",
                     green, yellow, red, active, phase);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        sense = 2'b10;
        for (int c = 0; c < 3; c++) step();
        checks++;
        if (phase !== 2'b00 || green !== 2'b01) begin
            errors++;
            $display("FAIL mid_resume_c3: got p=%b g=%b, want p=00 g=01", phase, green);
        end
        step();
        checks++;
        if (phase !== 2'b01 || yellow !== 2'b01) begin
            errors++;
            $display("FAIL mid_resume_c4: got p=%b y=%b, want p=01 y=01", phase, yellow);
        end
    endtask

    initial begin
        test_reset();
        test_min_switch();
        test_max_green();
        test_round_robin();
        test_late_demand();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_phase_light_ctrl.md
# multi_phase_light_ctrl

Parametrised N-approach traffic light controller. It generalises the two-road sensor-driven light FSM to `N_DIR` approaches with round-robin service, timed minimum/maximum green, fixed yellow and an all-red clearance interval. It sits between per-approach traffic sensors (one bit per approach) and the lamp drivers. Exactly one approach is ever non-red.

## Interface

Parameters:
- `N_DIR`, 2: number of approaches. Legal range 2..8.
- `CNT_W`, 8: phase timer width. Every duration parameter must be less than 2^CNT_W.
- `GREEN_MIN`, 4: minimum green length in cycles. Must be ≥1.
- `GREEN_MAX`, 16: green length after which a waiting approach forces a change. Must be ≥ `GREEN_MIN`.
- `YELLOW_T`, 3: yellow length in cycles. Must be ≥1.
- `ALLRED_T`, 1: all-red clearance length in cycles. Must be ≥1.

Ports:
- `clk` input, 1: clock.
- `rst` input, 1: reset; asynchronous, active-high.
- `sense` input, N_DIR: per-approach traffic present; sampled synchronously.
- `red` output, N_DIR: red lamp per approach.
- `yellow` output, N_DIR: yellow lamp per approach.
- `green` output, N_DIR: green lamp per approach.
- `active` output, clog2(N_DIR): index of the approach currently owning the phase.
- `phase` output, 2: 00 GREEN, 01 YELLOW, 10 ALLRED; 11 never driven.

## Operation

- State registers: `phase`, `active`, timer `t` (CNT_W). All are reset asynchronously.
- Reset values: `phase`=GREEN, `active`=0, `t`=0. Outputs after reset: `green`=1 on bit 0 only, `red`=all ones except bit 0, `yellow`=0.
- Outputs are Moore decodes of the registered state only:
  - `green[i]` = (phase==GREEN && active==i)
  - `yellow[i]` = (phase==YELLOW && active==i)
  - `red[i]` = not green[i] and not yellow[i]
  - In ALLRED, all `red` bits are 1.
- Define `other_req` = OR of `sense[j]` for every j ≠ `active`.
- GREEN:
  - `t` increments each cycle and saturates at GREEN_MAX-1.
  - Exit to YELLOW at the clock edge ending a cycle in which `other_req` is 1 and either:
    - `t` == GREEN_MAX-1, or
    - `t` ≥ GREEN_MIN-1 and `sense[active]` == 0.
  - With no `other_req`, GREEN holds indefinitely, including while `sense[active]` is 0.
- YELLOW: exits to ALLRED when `t` == YELLOW_T-1.
- ALLRED: exits to GREEN when `t` == ALLRED_T-1. On that same edge, `active` loads `next`:
  - `next` is the first j in the order active+1, active+2, …, wrapping, ending with active itself, for which `sense[j]` is 1 in that cycle.
  - If `sense` is all zero, `next` = (active+1) mod N_DIR.
- `t` clears to 0 on every phase transition.
- The yellow/all-red sequence is never aborted once started; sensor changes during it only affect `next` selection.
- Reset asserted in any phase returns immediately (asynchronously) to the reset values.

## Timing

- Green length: at least GREEN_MIN cycles. At most GREEN_MAX cycles while another approach is waiting. Unbounded otherwise.
- Yellow length: exactly YELLOW_T cycles. All-red length: exactly ALLRED_T cycles.
- Sensor-to-phase-change latency is one edge: a `sense` change in cycle k affects `phase` from cycle k+1.
- `active` changes only on the ALLRED→GREEN edge. It is stable and valid in every cycle.
- With defaults, a full switch after a minimal green takes 4+3+1 = 8 cycles. The new approach is green on the 9th cycle.
- No two approaches are simultaneously non-red in any cycle, including the cycle after reset release.

## Test plan

- Reset and idle: defaults, assert `rst` mid-cycle. Outputs go asynchronously to `green`=01, `red`=10, `yellow`=00, `active`=0, `phase`=00. With `sense`=01 held, they stay there for 100 cycles.
- Minimal switch: release reset with `sense`=10.
  - Cycles 0–3: `green[0]`.
  - Cycles 4–6: `yellow[0]`.
  - Cycle 7: all red.
  - Cycle 8: `green[1]` and `active`=1.
- Max-green preemption: `sense`=11 held. Each green lasts exactly 16 cycles before yellow. Approaches alternate 0,1,0,1.
- Round-robin skip: N_DIR=4. With `active`=0, `sense`=1000 in the last ALLRED cycle → `active`=3. With `sense`=0000 at that point → `active`=1.
- Late demand: `sense[1]` pulses high for a single cycle during GREEN with t<3. No exit occurs before t=3, and no exit occurs at all if `other_req` is absent at t≥3. Repeat with the pulse held through t=3: exit at t=3.
- Reset mid-sequence: assert `rst` during YELLOW of approach 1. In the same cycle the outputs return to `green`=01. Normal operation resumes from GREEN with t=0 after release.
